// File: rtl/wasm_pkg.sv
// wasm_pkg: shared definitions for the wasm_core execution core.
//   - opcode byte values of the supported instruction subset
//   - trap_e : trap codes reported on the core's trap output
//   - state_e: fetch/execute FSM states
// Optional feature macro: WASM_CORE_I64_ARITH_EN enables the i64 add/sub/mul
// opcodes in wasm_core; the opcode values live here unconditionally.
package wasm_pkg;

  localparam logic [7:0] OP_UNREACHABLE = 8'h00;
  localparam logic [7:0] OP_NOP         = 8'h01;
  localparam logic [7:0] OP_END         = 8'h0B;
  localparam logic [7:0] OP_DROP        = 8'h1A;
  localparam logic [7:0] OP_I32_CONST   = 8'h41;
  localparam logic [7:0] OP_I64_CONST   = 8'h42;
  localparam logic [7:0] OP_I32_EQZ     = 8'h45;
  localparam logic [7:0] OP_I64_EQZ     = 8'h50;
  localparam logic [7:0] OP_I64_EQ      = 8'h51;
  localparam logic [7:0] OP_I64_NE      = 8'h52;
  localparam logic [7:0] OP_I64_ADD     = 8'h7C;
  localparam logic [7:0] OP_I64_SUB     = 8'h7D;
  localparam logic [7:0] OP_I64_MUL     = 8'h7E;

  // A signed LEB128 encoding of a 64-bit value needs at most 10 bytes.
  localparam int LEB_MAX_BYTES = 10;

  typedef enum logic [3:0] {
    NONE        = 4'd0,
    UNREACHABLE = 4'd1,
    OVERFLOW    = 4'd2,
    UNDERFLOW   = 4'd3,
    MEM_ERROR   = 4'd4,
    ILLEGAL     = 4'd5
  } trap_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    TRAP  = 2'd3
  } state_e;

endpackage

// File: rtl/wasm_leb128_dec.sv
// wasm_leb128_dec: combinational signed-LEB128 immediate decoder.
// Ports:
//   i_bytes  [79:0] : up to 10 immediate bytes, byte k in bits [8k+7:8k]
//   i_is64          : 1 = i64 immediate (sign-extend to 64),
//                     0 = i32 immediate (32-bit value, zero-extended to 64)
//   o_value  [63:0] : decoded immediate
//   o_len    [3:0]  : number of bytes consumed (1..10)
// An encoding with no terminating byte inside the 10-byte slice is treated
// as 10 bytes long.
module wasm_leb128_dec
  import wasm_pkg::*;
(
  input  logic [8*LEB_MAX_BYTES-1:0] i_bytes,
  input  logic                       i_is64,
  output logic [63:0]                o_value,
  output logic [3:0]                 o_len
);

  localparam int ACC_W = 7 * LEB_MAX_BYTES;

  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_mask;
  logic [ACC_W-1:0] w_ext;
  logic             w_done;
  logic             w_sign;
  logic [3:0]       w_len;
  logic             w_unused_hi;

  // Gather 7-bit payload groups up to and including the first byte whose
  // continuation bit is clear; bit 6 of that byte is the sign.
  always_comb begin
    w_acc  = '0;
    w_done = 1'b0;
    w_len  = 4'(LEB_MAX_BYTES);
    w_sign = 1'b0;
    for (int i = 0; i < LEB_MAX_BYTES; i++) begin
      if (!w_done) begin
        w_acc[7*i +: 7] = i_bytes[8*i +: 7];
        w_len           = 4'(i + 1);
        w_sign          = i_bytes[8*i + 6];
        if (!i_bytes[8*i + 7]) w_done = 1'b1;
      end
    end
  end

  // Ones above the last payload bit; shifting by 70 leaves an empty mask.
  assign w_mask = {ACC_W{1'b1}} << (7'd7 * {3'b000, w_len});
  assign w_ext  = w_sign ? (w_acc | w_mask) : w_acc;

  assign o_value = i_is64 ? w_ext[63:0] : {32'd0, w_ext[31:0]};
  assign o_len   = w_len;

  // Bits 69:64 only hold payload that does not fit a 64-bit value.
  assign w_unused_hi = ^w_ext[ACC_W-1:64];

endmodule

// File: rtl/wasm_core.sv
// wasm_core: minimal WebAssembly stack-machine execution core.
// Fetches bytecode through a wide registered ROM window (genrom), executes a
// small integer opcode subset on a 64-bit operand stack.
// Ports:
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   result   [63:0]: top of stack, 0 when the stack is empty
//   result_empty   : stack holds no entries
//   trap     [3:0] : trap_e code, 0 = none
//   mem_addr       : byte address of fetch window (= pc)
//   mem_extra      : extra bytes requested beyond the first (all ones)
//   mem_data       : fetch window, byte k in bits [8k+7:8k], one cycle latency
//   mem_error      : window out of bounds, aligned with mem_data
//   dbg_state      : current FSM state
// Optional feature macro: WASM_CORE_I64_ARITH_EN adds i64.add/sub/mul
// (0x7C..0x7E); without it those opcodes trap as illegal.
// The window must hold at least 11 bytes (MEM_EXTRA >= 4): opcode plus the
// longest LEB128 immediate.
module wasm_core
  import wasm_pkg::*;
#(
  parameter int MEM_DEPTH   = 3,
  parameter int MEM_EXTRA   = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [63:0]                   result,
  output logic                          result_empty,
  output logic [3:0]                    trap,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error,
  output state_e                        dbg_state
);

  localparam int PC_W  = MEM_DEPTH + 1;
  localparam int WIN_W = (2**MEM_EXTRA) * 8;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int USE_W = 8 * (1 + LEB_MAX_BYTES);

  state_e           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [SP_W-1:0]  r_sp;
  trap_e            r_trap;
  logic [63:0]      r_stack [STACK_DEPTH];

  logic [7:0]       w_opcode;
  logic [63:0]      w_leb_value;
  logic [3:0]       w_leb_len;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_sec_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic [63:0]      w_top;
  logic [63:0]      w_sec;
  logic [1:0]       w_pops;
  logic             w_pushes;
  logic [63:0]      w_push_val;
  logic [3:0]       w_len;
  logic             w_halt;
  logic             w_unreach;
  logic             w_illegal;
  logic             w_underflow;
  logic             w_overflow;
  logic [SP_W:0]    w_sp_after;
  logic [SP_W-1:0]  w_sp_next;
  trap_e            w_fault;
  logic             w_unused_win;

  assign w_opcode = mem_data[7:0];

  wasm_leb128_dec u_leb (
    .i_bytes (mem_data[USE_W-1:8]),
    .i_is64  (w_opcode == OP_I64_CONST),
    .o_value (w_leb_value),
    .o_len   (w_leb_len)
  );

  // Bytes past the opcode and the longest immediate are never decoded.
  assign w_unused_win = ^mem_data[WIN_W-1:USE_W];

  // Operand reads; indices wrap harmlessly when the stack is too shallow
  // because the underflow check blocks any commit in that case.
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign w_sec_idx = IDX_W'(r_sp - SP_W'(2));
  assign w_wr_idx  = IDX_W'(r_sp - SP_W'(w_pops));
  assign w_top     = r_stack[w_top_idx];
  assign w_sec     = r_stack[w_sec_idx];

  // Instruction decode: stack effect, pushed value and length.
  always_comb begin
    w_pops     = 2'd0;
    w_pushes   = 1'b0;
    w_push_val = 64'd0;
    w_len      = 4'd1;
    w_halt     = 1'b0;
    w_unreach  = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OP_UNREACHABLE: w_unreach = 1'b1;
      OP_NOP:         ;
      OP_END:         w_halt = 1'b1;
      OP_DROP:        w_pops = 2'd1;
      OP_I32_CONST, OP_I64_CONST: begin
        w_pushes   = 1'b1;
        w_push_val = w_leb_value;
        w_len      = 4'd1 + w_leb_len;
      end
      OP_I32_EQZ: begin
        w_pops     = 2'd1;
        w_pushes   = 1'b1;
        w_push_val = {63'd0, (w_top[31:0] == 32'd0)};
      end
      OP_I64_EQZ: begin
        w_pops     = 2'd1;
        w_pushes   = 1'b1;
        w_push_val = {63'd0, (w_top == 64'd0)};
      end
      OP_I64_EQ: begin
        w_pops     = 2'd2;
        w_pushes   = 1'b1;
        w_push_val = {63'd0, (w_sec == w_top)};
      end
      OP_I64_NE: begin
        w_pops     = 2'd2;
        w_pushes   = 1'b1;
        w_push_val = {63'd0, (w_sec != w_top)};
      end
`ifdef WASM_CORE_I64_ARITH_EN
      OP_I64_ADD: begin
        w_pops     = 2'd2;
        w_pushes   = 1'b1;
        w_push_val = w_sec + w_top;
      end
      OP_I64_SUB: begin
        w_pops     = 2'd2;
        w_pushes   = 1'b1;
        w_push_val = w_sec - w_top;
      end
      OP_I64_MUL: begin
        w_pops     = 2'd2;
        w_pushes   = 1'b1;
        w_push_val = w_sec * w_top;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Stack depth after the instruction, one bit wider so a push onto a full
  // stack is seen as exceeding STACK_DEPTH rather than wrapping.
  assign w_underflow = (r_sp < SP_W'(w_pops));
  assign w_sp_after  = {1'b0, r_sp} - (SP_W+1)'(w_pops) + (SP_W+1)'(w_pushes);
  assign w_overflow  = (w_sp_after > (SP_W+1)'(STACK_DEPTH));
  assign w_sp_next   = w_sp_after[SP_W-1:0];

  // Fault priority: mem_error > underflow > overflow > illegal/unreachable.
  always_comb begin
    w_fault = NONE;
    if (mem_error)        w_fault = MEM_ERROR;
    else if (w_underflow) w_fault = UNDERFLOW;
    else if (w_overflow)  w_fault = OVERFLOW;
    else if (w_illegal)   w_fault = ILLEGAL;
    else if (w_unreach)   w_fault = UNREACHABLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_sp    <= '0;
      r_trap  <= NONE;
    end else begin
      case (r_state)
        FETCH: r_state <= EXEC;
        EXEC: begin
          if (w_fault != NONE) begin
            r_trap  <= w_fault;
            r_state <= TRAP;
          end else if (w_halt) begin
            r_state <= HALT;
          end else begin
            r_pc    <= r_pc + PC_W'(w_len);
            r_sp    <= w_sp_next;
            r_state <= FETCH;
          end
        end
        default: ; // HALT and TRAP hold everything until reset
      endcase
    end
  end

  // Stack storage carries no reset: clearing the stack pointer discards it.
  always_ff @(posedge clk) begin
    if (r_state == EXEC && w_fault == NONE && !w_halt && w_pushes)
      r_stack[w_wr_idx] <= w_push_val;
  end

  assign mem_addr     = r_pc;
  assign mem_extra    = '1;
  assign result_empty = (r_sp == '0);
  assign result       = result_empty ? 64'd0 : w_top;
  assign trap         = r_trap;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_wasm_core.sv
// tb_wasm_core: directed programs run from a registered ROM model; the driver
// queues the expected final core status when it loads a program and a
// separate monitor compares it against the core when the driver strobes obs.
module tb_wasm_core;
  import wasm_pkg::*;

  localparam int MEM_DEPTH   = 3;
  localparam int MEM_EXTRA   = 4;
  localparam int STACK_DEPTH = 16;
  localparam int WIN_B       = 2**MEM_EXTRA;
  localparam int ROM_B       = 2**(MEM_DEPTH+1);
  localparam int W           = 75;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [63:0]            result;
  logic                   result_empty;
  logic [3:0]             trap;
  logic [MEM_DEPTH:0]     mem_addr;
  logic [MEM_EXTRA-1:0]   mem_extra;
  logic [WIN_B*8-1:0]     mem_data = '0;
  logic                   mem_error = 1'b0;
  state_e                 dbg_state;

  logic [7:0]             rom [ROM_B];
  int                     rom_len = 0;

  logic [W-1:0]           exp_q[$];
  string                  name_q[$];
  logic                   obs = 1'b0;
  logic                   timed_out = 1'b0;
  int                     n_cmp = 0;
  int                     n_bad = 0;
  bit                     ok;

  wasm_core #(
    .MEM_DEPTH   (MEM_DEPTH),
    .MEM_EXTRA   (MEM_EXTRA),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_empty (result_empty),
    .trap         (trap),
    .mem_addr     (mem_addr),
    .mem_extra    (mem_extra),
    .mem_data     (mem_data),
    .mem_error    (mem_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model (genrom) ----------------
  // Registered window read with wrap-around; addresses at or beyond rom_len
  // are flagged as out of bounds.
  always @(posedge clk) begin
    for (int k = 0; k < WIN_B; k++)
      mem_data[8*k +: 8] <= rom[(int'(mem_addr) + k) % ROM_B];
    mem_error <= (int'(mem_addr) >= rom_len);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    string        nm;
    if (obs) begin
      act = {2'(dbg_state), mem_extra, trap, result_empty, result};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL no_expectation: observed %h with empty queue", act);
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (timed_out) begin
          n_bad++;
          $display("FAIL %s: no HALT/TRAP within cycle budget, state=%0d", nm, act[74:73]);
        end else if (act !== exp_v) begin
          n_bad++;
          $display("FAIL %s: got state=%0d extra=%h trap=%0d empty=%0b result=%h, expected state=%0d extra=%h trap=%0d empty=%0b result=%h",
                   nm, act[74:73], act[72:69], act[68:65], act[64], act[63:0],
                   exp_v[74:73], exp_v[72:69], exp_v[68:65], exp_v[64], exp_v[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] pack(input state_e st, input logic [3:0] tr,
                                        input logic emp, input logic [63:0] res);
    return {2'(st), 4'hF, tr, emp, res};
  endfunction

  task automatic push_exp(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // prog is written big-endian: its first byte is the leftmost hex pair.
  task automatic load(input logic [127:0] prog, input int nbytes, input int rlen);
    for (int i = 0; i < ROM_B; i++) rom[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) rom[i] = prog[8*(nbytes-1-i) +: 8];
    rom_len = rlen;
  endtask

  task automatic observe(input bit to);
    timed_out = to;
    obs = 1'b1;
    @(negedge clk);
    #1 obs = 1'b0;
  endtask

  task automatic wait_final(input int max_cyc, output bit done);
    done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (dbg_state == HALT || dbg_state == TRAP) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string nm, input logic [127:0] prog, input int nbytes,
                     input int rlen, input int max_cyc, input logic [W-1:0] exp_v);
    bit done;
    reset = 1'b0;
    load(prog, nbytes, rlen);
    push_exp(nm, exp_v);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_final(max_cyc, done);
    // Two extra cycles confirm the final state holds.
    repeat (2) @(posedge clk);
    #1;
    observe(!done);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < ROM_B; i++) rom[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_state", pack(FETCH, 4'd0, 1'b1, 64'd0));
    observe(1'b0);

    run("i64eqz_zero",       128'h4200500B, 4, 4, 9,   pack(HALT, 4'd0, 1'b0, 64'd1));
    run("i64eqz_nonzero",    128'h4205500B, 4, 4, 100, pack(HALT, 4'd0, 1'b0, 64'd0));
    run("i64const_neg1",     128'h427F0B, 3, 3, 100,   pack(HALT, 4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
    run("i32const_neg1",     128'h417F0B, 3, 3, 100,   pack(HALT, 4'd0, 1'b0, 64'h0000_0000_FFFF_FFFF));
    run("leb_multi_pos",     128'h42E58E260B, 5, 5, 100, pack(HALT, 4'd0, 1'b0, 64'h0000_0000_0009_8765));
    run("leb_multi_neg",     128'h42C0BB780B, 5, 5, 100, pack(HALT, 4'd0, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0));
    run("i32const_multi_neg",128'h41C0BB780B, 5, 5, 100, pack(HALT, 4'd0, 1'b0, 64'h0000_0000_FFFE_1DC0));
    run("leb_10byte_min",    128'h428080808080808080807F0B, 12, 12, 100,
        pack(HALT, 4'd0, 1'b0, 64'h8000_0000_0000_0000));
    run("i32eqz_hi_only",    128'h428080808010450B, 8, 8, 100, pack(HALT, 4'd0, 1'b0, 64'd1));
    run("end_only",          128'h0B, 1, 1, 100,       pack(HALT, 4'd0, 1'b1, 64'd0));
    run("i64eqz_underflow",  128'h500B, 2, 2, 100,     pack(TRAP, 4'd3, 1'b1, 64'd0));
    run("unreachable",       128'h00, 1, 1, 100,       pack(TRAP, 4'd1, 1'b1, 64'd0));
    run("illegal_ff",        128'hFF, 1, 1, 100,       pack(TRAP, 4'd5, 1'b1, 64'd0));
    run("i64eq_true",        128'h42014201510B, 6, 6, 100, pack(HALT, 4'd0, 1'b0, 64'd1));
    run("i64eq_false",       128'h42014202510B, 6, 6, 100, pack(HALT, 4'd0, 1'b0, 64'd0));
    run("i64ne_equal",       128'h42034203520B, 6, 6, 100, pack(HALT, 4'd0, 1'b0, 64'd0));
    run("i64ne_drop",        128'h42014202521A0B, 7, 7, 100, pack(HALT, 4'd0, 1'b1, 64'd0));
    run("eq_underflow_one",  128'h4201510B, 4, 4, 100, pack(TRAP, 4'd3, 1'b0, 64'd1));
    // 8 pushes per pass; pc wraps so the 17th push overflows a full stack.
    run("overflow_wrap",     128'h42014202420342044205420642074208, 16, 16, 100,
        pack(TRAP, 4'd2, 1'b0, 64'd8));
    // pc=1 is out of bounds; the drop there would underflow but mem_error wins.
    run("mem_error_prio",    128'h011A, 2, 1, 100,     pack(TRAP, 4'd4, 1'b1, 64'd0));
`ifdef WASM_CORE_I64_ARITH_EN
    run("i64_sub",           128'h420542037D0B, 6, 6, 100, pack(HALT, 4'd0, 1'b0, 64'd2));
    run("i64_add_wrap",      128'h427F42027C0B, 6, 6, 100, pack(HALT, 4'd0, 1'b0, 64'd1));
    run("i64_mul",           128'h427F42037E0B, 6, 6, 100,
        pack(HALT, 4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD));
`else
    run("arith_illegal",     128'h420542037D0B, 6, 6, 100, pack(TRAP, 4'd5, 1'b0, 64'd3));
`endif

    // Reset while the second instruction is executing, then rerun.
    reset = 1'b0;
    load(128'h422A42070B, 5, 5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (dbg_state == EXEC && !result_empty) begin
        ok = 1'b1;
        break;
      end
    end
    push_exp("reset_mid_exec", pack(FETCH, 4'd0, 1'b1, 64'd0));
    reset = 1'b0;
    #1;
    observe(!ok);
    push_exp("rerun_after_reset", pack(HALT, 4'd0, 1'b0, 64'd7));
    @(posedge clk);
    #1 reset = 1'b1;
    wait_final(20, ok);
    repeat (2) @(posedge clk);
    #1;
    observe(!ok);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
